alien_bomb_launcher: RTL
========================

Name: alien_bomb_launcher

Overview:
Enemy-fire source for the alien matrix. It consumes the matrix's per-pixel outputs (alienMatrixDR, bottomAlien, alienMiddleX/Y, alienType) and picks a bottom-row alien as the shooter. After a pseudo-random delay it drops a bomb from that alien. The bomb moves downward once per frame until it hits something or leaves the screen. Outputs are a drawing request and RGB for the video mux, plus bomb position and state for collision logic.

Parameters:
BOMB_W, 4, bomb width in pixels
BOMB_H, 16, bomb height in pixels
SPEED_Y, 4, base fall speed in px/frame; actual speed = SPEED_Y + alienType
ALIEN_HALF_H, 16, vertical distance from alien middle to bomb spawn TLY
SCREEN_BOTTOM, 479, last visible row
MIN_DELAY, 16, minimum frames between bombs
DELAY_MASK, 63, mask applied to the LFSR for the extra random delay
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero
EXPLODE_FRAMES, 8, frames the explosion is shown
BOMB_COLOR, 8'hFC, RGB while falling
EXPLODE_COLOR, 8'hE0, RGB while exploding

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per frame
standBy  in  1  game in standby
gameEnded  in  1  game over
pixelX  in  11  current scan X
pixelY  in  11  current scan Y
alienMatrixDR  in  1  alien pixel drawn
bottomAlien  in  1  current alien is lowest in its column
alienMiddleX  in  11  center X of current alien
alienMiddleY  in  11  center Y of current alien
alienType  in  2  type of current alien
bombCollision  in  1  bomb pixel overlaps player, shield or shot
bombDR  out  1  bomb drawing request
bombRGB  out  8  bomb color
bombActive  out  1  high in state FALL
bombTLX  out  11  bomb top-left X
bombTLY  out  11  bomb top-left Y

Behaviour:
- Clock and reset: single clock clk. Reset resetN is asynchronous and active-low.
- Reset values: state IDLE; delay = MIN_DELAY; lfsr = LFSR_SEED; candidate registers invalid. All outputs 0.
- playGame = ~(standBy | gameEnded). When playGame is low, on the next clock: state becomes IDLE, delay = MIN_DELAY, bombDR = 0. The LFSR keeps running.
- LFSR: 16-bit Galois, taps 16'hB400. Advances once per startOfFrame and never reaches zero.
- targetX = {lfsr[8:0],1'b0}. It is latched at startOfFrame and held for the whole frame.
- Candidate capture, on any cycle with alienMatrixDR & bottomAlien:
  - Fallback register (X, Y, type) always loads.
  - Primary register loads only if it is not yet valid and alienMiddleX >= targetX.
  - Both are cleared at startOfFrame, after their contents are copied into chosen = primary if valid, else fallback if valid, else none.
- FSM advances on startOfFrame only, except for collision.
  - IDLE: if delay != 0, delay-1. If delay == 0 and chosen is valid: TLX = chosenX - BOMB_W/2 (clamped to 0 on underflow), TLY = chosenY + ALIEN_HALF_H, latch speed = SPEED_Y + chosenType, go to FALL. If delay == 0 and nothing is chosen, stay in IDLE and retry next frame.
  - FALL: nextY = TLY + speed. If nextY + BOMB_H > SCREEN_BOTTOM, go to IDLE and reload delay = MIN_DELAY + (lfsr & DELAY_MASK). Otherwise TLY = nextY.
  - FALL with bombCollision & bombDR, on any cycle: next cycle go to EXPLODE, position frozen, explode counter = EXPLODE_FRAMES. Collision wins over a same-cycle startOfFrame, so no move happens.
  - EXPLODE: decrement the counter per startOfFrame. On reaching 0, go to IDLE and reload delay as above. bombCollision is ignored in EXPLODE and IDLE.
- Drawing, registered with 1-cycle latency:
  - bombDR = (state != IDLE) & TLX <= pixelX < TLX+BOMB_W & TLY <= pixelY < TLY+BOMB_H.
  - bombRGB = BOMB_COLOR in FALL, EXPLODE_COLOR in EXPLODE, 0 when bombDR is low.
- Arithmetic: all coordinates 11-bit unsigned. Comparisons are done at 12 bits to avoid wrap.

Decomposition:
- Package alien_bomb_pkg holds:
  - state enum {IDLE, FALL, EXPLODE}
  - LFSR tap constant
  - color constants
- Sub-module bomb_lfsr (16-bit Galois; ports clk, resetN, step, value).

Test Plan:
1. Assert resetN=0 mid-frame -> all outputs 0 immediately; after release, state IDLE with no bomb for MIN_DELAY frames.
2. MIN_DELAY=2, DELAY_MASK=0; one bottom alien at middle (200,100), type 0 -> at the 3rd startOfFrame, bombTLX=198, bombTLY=116, bombActive=1; TLY then goes 120, 124 on the next frames. bombDR=1 one cycle after pixel (198,116) is presented.
3. Bomb falling; assert bombCollision together with startOfFrame while bombDR=1 -> EXPLODE, TLY unchanged, bombRGB=8'hE0 for 8 frames, then IDLE with bombDR=0.
4. TLY=460, speed 4 -> nextY=464, 464+16=480>479 -> IDLE, bombActive=0, delay reloaded.
5. Candidate with alienType=3 -> TLY increases by 7 per frame.
6. Assert standBy mid-FALL -> IDLE next cycle, bombDR=0. Release standBy -> no new bomb for MIN_DELAY frames.

Source files
------------

// File: rtl/alien_bomb_pkg.sv
// Shared types and constants for the alien bomb launcher.
package alien_bomb_pkg;

  // Bomb life cycle: waiting to fire, dropping, showing the explosion.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FALL    = 2'd1,
    EXPLODE = 2'd2
  } bombState_t;

  // Galois feedback taps for a maximal-length 16-bit right-shifting LFSR.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Default colors for the falling bomb and for the explosion.
  localparam logic [7:0] BOMB_COLOR_DEF    = 8'hFC;
  localparam logic [7:0] EXPLODE_COLOR_DEF = 8'hE0;

  // One Galois step: shift right and fold the taps in when a one drops out.
  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = v >> 1;
    if (v[0]) begin
      lfsrStep = shifted ^ LFSR_TAPS;
    end else begin
      lfsrStep = shifted;
    end
  endfunction

endpackage

// File: rtl/bomb_lfsr.sv
// 16-bit Galois LFSR that advances once per step pulse; a nonzero seed keeps
// it out of the all-zero lock-up state forever.
module bomb_lfsr
  import alien_bomb_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        step,
  output logic [15:0] value
);

  // Advance the pseudo-random sequence on each step pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      value <= SEED;
    end else if (step) begin
      value <= lfsrStep(value);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/alien_bomb_launcher.sv
// Enemy-fire source: picks a bottom-row alien as shooter, waits a random
// number of frames, then drops a bomb that falls once per frame until it
// reaches the bottom of the screen or hits something.
module alien_bomb_launcher
  import alien_bomb_pkg::*;
#(
  parameter int          BOMB_W         = 4,
  parameter int          BOMB_H         = 16,
  parameter int          SPEED_Y        = 4,
  parameter int          ALIEN_HALF_H   = 16,
  parameter int          SCREEN_BOTTOM  = 479,
  parameter int          MIN_DELAY      = 16,
  parameter int          DELAY_MASK     = 63,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          EXPLODE_FRAMES = 8,
  parameter logic [7:0]  BOMB_COLOR     = BOMB_COLOR_DEF,
  parameter logic [7:0]  EXPLODE_COLOR  = EXPLODE_COLOR_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        standBy,
  input  logic        gameEnded,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        alienMatrixDR,
  input  logic        bottomAlien,
  input  logic [10:0] alienMiddleX,
  input  logic [10:0] alienMiddleY,
  input  logic [1:0]  alienType,
  input  logic        bombCollision,
  output logic        bombDR,
  output logic [7:0]  bombRGB,
  output logic        bombActive,
  output logic [10:0] bombTLX,
  output logic [10:0] bombTLY
);

  logic        playGame_s;
  logic        capture_s;
  logic [15:0] lfsrValue_s;
  logic [15:0] reloadDelay_s;
  logic [11:0] spawnX_s;
  logic [10:0] spawnY_s;
  logic [11:0] nextY_s;
  logic        bottomHit_s;
  logic        inside_s;

  logic [10:0] targetX_r;
  logic        primValid_r;
  logic [10:0] primX_r;
  logic [10:0] primY_r;
  logic [1:0]  primType_r;
  logic        fbValid_r;
  logic [10:0] fbX_r;
  logic [10:0] fbY_r;
  logic [1:0]  fbType_r;
  logic        chosenValid_r;
  logic [10:0] chosenX_r;
  logic [10:0] chosenY_r;
  logic [1:0]  chosenType_r;

  bombState_t  state_r;
  logic [15:0] delay_r;
  logic [7:0]  explodeCnt_r;
  logic [7:0]  speed_r;
  logic [10:0] tlx_r;
  logic [10:0] tly_r;
  logic        bombDR_r;
  logic [7:0]  bombRGB_r;

  bomb_lfsr #(
    .SEED (LFSR_SEED)
  ) uLfsr (
    .clk    (clk),
    .resetN (resetN),
    .step   (startOfFrame),
    .value  (lfsrValue_s)
  );

  assign playGame_s    = ~(standBy | gameEnded);
  assign capture_s     = alienMatrixDR & bottomAlien;
  assign reloadDelay_s = 16'(MIN_DELAY) + (lfsrValue_s & 16'(DELAY_MASK));
  assign spawnY_s      = 11'({1'b0, chosenY_r} + 12'(ALIEN_HALF_H));
  assign nextY_s       = {1'b0, tly_r} + 12'(speed_r);
  assign bottomHit_s   = (nextY_s + 12'(BOMB_H)) > 12'(SCREEN_BOTTOM);

  // Spawn X centres the bomb under the shooter, clamped at the left edge.
  always_comb begin
    spawnX_s = 12'd0;
    if ({1'b0, chosenX_r} >= 12'(BOMB_W / 2)) begin
      spawnX_s = {1'b0, chosenX_r} - 12'(BOMB_W / 2);
    end else begin
      spawnX_s = 12'd0;
    end
  end

  // Pixel-in-bomb test done at 12 bits so TLX+W / TLY+H cannot wrap.
  always_comb begin
    inside_s = 1'b0;
    if (({1'b0, pixelX} >= {1'b0, tlx_r}) &&
        ({1'b0, pixelX} <  ({1'b0, tlx_r} + 12'(BOMB_W))) &&
        ({1'b0, pixelY} >= {1'b0, tly_r}) &&
        ({1'b0, pixelY} <  ({1'b0, tly_r} + 12'(BOMB_H)))) begin
      inside_s = 1'b1;
    end else begin
      inside_s = 1'b0;
    end
  end

  // Shooter selection: latch a random target column each frame, track the
  // first bottom alien at or right of it plus the last one seen as fallback.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      targetX_r     <= 11'd0;
      primValid_r   <= 1'b0;
      primX_r       <= 11'd0;
      primY_r       <= 11'd0;
      primType_r    <= 2'd0;
      fbValid_r     <= 1'b0;
      fbX_r         <= 11'd0;
      fbY_r         <= 11'd0;
      fbType_r      <= 2'd0;
      chosenValid_r <= 1'b0;
      chosenX_r     <= 11'd0;
      chosenY_r     <= 11'd0;
      chosenType_r  <= 2'd0;
    end else if (startOfFrame) begin
      targetX_r <= {lfsrValue_s[8:0], 1'b0};
      if (primValid_r) begin
        chosenValid_r <= 1'b1;
        chosenX_r     <= primX_r;
        chosenY_r     <= primY_r;
        chosenType_r  <= primType_r;
      end else if (fbValid_r) begin
        chosenValid_r <= 1'b1;
        chosenX_r     <= fbX_r;
        chosenY_r     <= fbY_r;
        chosenType_r  <= fbType_r;
      end else begin
        chosenValid_r <= 1'b0;
      end
      primValid_r <= 1'b0;
      fbValid_r   <= 1'b0;
    end else if (capture_s) begin
      fbValid_r <= 1'b1;
      fbX_r     <= alienMiddleX;
      fbY_r     <= alienMiddleY;
      fbType_r  <= alienType;
      if (!primValid_r && ({1'b0, alienMiddleX} >= {1'b0, targetX_r})) begin
        primValid_r <= 1'b1;
        primX_r     <= alienMiddleX;
        primY_r     <= alienMiddleY;
        primType_r  <= alienType;
      end
    end
  end

  // Bomb state machine: frame-paced delay, fall and explosion; a collision
  // while visible pre-empts everything else except leaving play.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= IDLE;
      delay_r      <= 16'(MIN_DELAY);
      explodeCnt_r <= 8'd0;
      speed_r      <= 8'd0;
      tlx_r        <= 11'd0;
      tly_r        <= 11'd0;
    end else if (!playGame_s) begin
      state_r <= IDLE;
      delay_r <= 16'(MIN_DELAY);
    end else if ((state_r == FALL) && bombCollision && bombDR_r) begin
      state_r      <= EXPLODE;
      explodeCnt_r <= 8'(EXPLODE_FRAMES);
    end else if (startOfFrame) begin
      case (state_r)
        IDLE: begin
          if (delay_r != 16'd0) begin
            delay_r <= delay_r - 16'd1;
          end else if (chosenValid_r) begin
            tlx_r   <= spawnX_s[10:0];
            tly_r   <= spawnY_s;
            speed_r <= 8'(SPEED_Y) + {6'd0, chosenType_r};
            state_r <= FALL;
          end
        end
        FALL: begin
          if (bottomHit_s) begin
            state_r <= IDLE;
            delay_r <= reloadDelay_s;
          end else begin
            tly_r <= nextY_s[10:0];
          end
        end
        EXPLODE: begin
          if (explodeCnt_r < 8'd2) begin
            explodeCnt_r <= 8'd0;
            state_r      <= IDLE;
            delay_r      <= reloadDelay_s;
          end else begin
            explodeCnt_r <= explodeCnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Registered drawing request and color, one cycle behind the pixel.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bombDR_r  <= 1'b0;
      bombRGB_r <= 8'h00;
    end else if (playGame_s && (state_r != IDLE) && inside_s) begin
      bombDR_r  <= 1'b1;
      bombRGB_r <= (state_r == FALL) ? BOMB_COLOR : EXPLODE_COLOR;
    end else begin
      bombDR_r  <= 1'b0;
      bombRGB_r <= 8'h00;
    end
  end

  assign bombDR     = bombDR_r;
  assign bombRGB    = bombRGB_r;
  assign bombActive = (state_r == FALL);
  assign bombTLX    = tlx_r;
  assign bombTLY    = tly_r;

endmodule
